// File: rtl/bram_rr_arbiter.sv
// Round-robin share of one single-port RAM between two requesters, with a bounded burst hold.
// gnt is combinational (0 cycles); reads return RD_LAT cycles after grant; losers hold req.
module bram_rr_arbiter #(
  parameter int AW        = 4,
  parameter int DW        = 16,
  parameter int RD_LAT    = 1,
  parameter int MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout
);

  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_M0   = 2'd1,
    OWN_M1   = 2'd2
  } owner_e;

  owner_e        owner_q, owner_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          last_q, last_d;
  logic          win0, win1;
  logic          burst_open;
  logic          rd_xfer;
  logic [RD_LAT-1:0] tag_vld;
  logic [RD_LAT-1:0] tag_id;

  assign burst_open = (cnt_q < CW'(MAX_BURST));

  // Winner selection and next state; win0/win1 are the ungated grants.
  always_comb begin
    win0    = 1'b0;
    win1    = 1'b0;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    case (owner_q)
      OWN_M0: begin
        if (m0_req && (burst_open || !m1_req)) win0 = 1'b1;
        else if (m1_req)                       win1 = 1'b1;
      end
      OWN_M1: begin
        if (m1_req && (burst_open || !m0_req)) win1 = 1'b1;
        else if (m0_req)                       win0 = 1'b1;
      end
      default: begin
        if (m0_req && m1_req) begin
          win0 = last_q;
          win1 = !last_q;
        end else begin
          win0 = m0_req;
          win1 = m1_req;
        end
      end
    endcase

    if (win0 || win1) begin
      last_d = win1;
      if ((win0 && owner_q == OWN_M0) || (win1 && owner_q == OWN_M1)) begin
        if (burst_open) cnt_d = cnt_q + CW'(1);
      end else begin
        owner_d = win1 ? OWN_M1 : OWN_M0;
        cnt_d   = CW'(1);
      end
    end else begin
      owner_d = OWN_NONE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_q <= OWN_NONE;
      cnt_q   <= '0;
      last_q  <= 1'b1;
    end else begin
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end

  // Reset gates only the outputs so it never feeds a flop's D input.
  assign m0_gnt   = win0 & rst;
  assign m1_gnt   = win1 & rst;
  assign ram_we   = ((win0 & m0_we) | (win1 & m1_we)) & rst;
  assign ram_addr = win1 ? m1_addr  : m0_addr;
  assign ram_din  = win1 ? m1_wdata : m0_wdata;
  assign rd_xfer  = (win0 & !m0_we) | (win1 & !m1_we);

  // Tag pipeline mirrors the RAM read latency; reset drops in-flight reads.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tag_vld <= '0;
      tag_id  <= '0;
    end else begin
      tag_vld[0] <= rd_xfer;
      tag_id[0]  <= win1;
      for (int i = 1; i < RD_LAT; i++) begin
        tag_vld[i] <= tag_vld[i-1];
        tag_id[i]  <= tag_id[i-1];
      end
    end
  end

  assign m0_rvalid = tag_vld[RD_LAT-1] & !tag_id[RD_LAT-1];
  assign m1_rvalid = tag_vld[RD_LAT-1] &  tag_id[RD_LAT-1];
  assign m0_rdata  = ram_dout;
  assign m1_rdata  = ram_dout;

endmodule

// File: tb/tb_bram_rr_arbiter.sv
// Scoreboard bench for bram_rr_arbiter with a latency-accurate RAM model and a history-based arbitration model.
module tb_bram_rr_arbiter;
  localparam int AW = 4, DW = 16, RD_LAT = 2, MAX_BURST = 4;

  typedef struct { logic we; logic [AW-1:0] addr; logic [DW-1:0] wdata; } tx_t;
  typedef struct { int w; logic we; logic [AW-1:0] addr; logic [DW-1:0] wdata; } ge_t;
  typedef struct { int id; logic [DW-1:0] data; int due; } rd_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic m0_req, m0_we, m0_gnt, m0_rvalid;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata, m0_rdata;
  logic m1_req, m1_we, m1_gnt, m1_rvalid;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata, m1_rdata;
  logic ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din, ram_dout;

  always #5 clk = ~clk;

  bram_rr_arbiter #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  // Single-port RAM with RD_LAT cycles of read latency.
  logic [DW-1:0] mem [2**AW];
  logic [DW-1:0] rpipe [RD_LAT];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    rpipe[0] <= mem[ram_addr];
    for (int i = 1; i < RD_LAT; i++) rpipe[i] <= rpipe[i-1];
  end
  assign ram_dout = rpipe[RD_LAT-1];

  tx_t q0[$], q1[$];
  ge_t gq[$];
  rd_t rdq[$];
  int  hist[$];
  int  dlog[$];
  logic [DW-1:0] ref_mem [2**AW];
  bit  act0 = 1'b0, act1 = 1'b0;
  int  prob = 100;
  int  nsteps = 0;
  int  checks = 0, errors = 0;
  int  cyc = 0;
  ge_t mon_e;
  rd_t mon_r;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic issue(input int id, input bit we, input int addr, input logic [DW-1:0] d);
    tx_t t;
    t.we = we; t.addr = addr[AW-1:0]; t.wdata = d;
    if (id == 0) q0.push_back(t); else q1.push_back(t);
  endtask

  // Arbitration rules applied to the grant history since reset.
  function automatic int model_winner(bit r0, bit r1);
    int lst, prev, run;
    if (!r0 && !r1) return -1;
    if (r0 != r1) return r0 ? 0 : 1;
    lst = 1;
    for (int i = hist.size() - 1; i >= 0; i--)
      if (hist[i] >= 0) begin lst = hist[i]; break; end
    prev = (hist.size() > 0) ? hist[hist.size()-1] : -1;
    if (prev < 0) return 1 - lst;
    run = 0;
    for (int i = hist.size() - 1; i >= 0 && hist[i] == prev; i--) run++;
    return (run < MAX_BURST) ? prev : 1 - prev;
  endfunction

  task automatic step(input bit r);
    tx_t t0, t1, t;
    ge_t e;
    rd_t rd;
    int  w;
    @(posedge clk); #1;
    rst = r;
    if (!act0 && q0.size() > 0 && int'($urandom_range(99)) < prob) act0 = 1'b1;
    if (!act1 && q1.size() > 0 && int'($urandom_range(99)) < prob) act1 = 1'b1;
    if (act0) t0 = q0[0];
    else begin t0.we = 1'($urandom_range(1)); t0.addr = AW'($urandom); t0.wdata = DW'($urandom); end
    if (act1) t1 = q1[0];
    else begin t1.we = 1'($urandom_range(1)); t1.addr = AW'($urandom); t1.wdata = DW'($urandom); end
    m0_req = act0; m0_we = t0.we; m0_addr = t0.addr; m0_wdata = t0.wdata;
    m1_req = act1; m1_we = t1.we; m1_addr = t1.addr; m1_wdata = t1.wdata;
    w = r ? model_winner(act0, act1) : -1;
    t = (w == 1) ? t1 : t0;
    e.w = w; e.we = t.we; e.addr = t.addr; e.wdata = t.wdata;
    gq.push_back(e);
    nsteps++;
    if (!r) begin
      hist.delete();
      rdq.delete();
    end else begin
      hist.push_back(w);
      if (hist.size() > 32) void'(hist.pop_front());
    end
    if (w >= 0) begin
      if (w == 0) begin void'(q0.pop_front()); act0 = 1'b0; end
      else        begin void'(q1.pop_front()); act1 = 1'b0; end
      if (t.we) ref_mem[t.addr] = t.wdata;
      else begin
        rd.id = w; rd.data = ref_mem[t.addr]; rd.due = cyc + RD_LAT;
        rdq.push_back(rd);
      end
    end
  endtask

  task automatic sync();
    @(negedge clk); #1;
  endtask

  // Monitor: grant/RAM-drive expectations per cycle, read returns by due cycle.
  always @(negedge clk) begin
    if (gq.size() > 0) begin
      mon_e = gq.pop_front();
      chk(m0_gnt === (mon_e.w == 0), "m0_gnt", 32'(m0_gnt), 32'(mon_e.w == 0));
      chk(m1_gnt === (mon_e.w == 1), "m1_gnt", 32'(m1_gnt), 32'(mon_e.w == 1));
      chk(ram_we === (mon_e.w >= 0 && mon_e.we), "ram_we", 32'(ram_we), 32'(mon_e.w >= 0 && mon_e.we));
      if (mon_e.w >= 0) begin
        chk(ram_addr === mon_e.addr, "ram_addr", 32'(ram_addr), 32'(mon_e.addr));
        if (mon_e.we) chk(ram_din === mon_e.wdata, "ram_din", 32'(ram_din), 32'(mon_e.wdata));
      end
      dlog.push_back(m0_gnt ? 0 : (m1_gnt ? 1 : -1));
    end
    if (m0_rvalid === 1'b1 || m1_rvalid === 1'b1) begin
      chk(rdq.size() > 0, "unexpected_rvalid", {30'd0, m1_rvalid, m0_rvalid}, 32'd0);
      if (rdq.size() > 0) begin
        mon_r = rdq.pop_front();
        chk(mon_r.due == cyc, "rvalid_cycle", cyc, mon_r.due);
        chk({m1_rvalid, m0_rvalid} === ((mon_r.id == 0) ? 2'b01 : 2'b10), "rvalid_route",
            {30'd0, m1_rvalid, m0_rvalid}, (mon_r.id == 0) ? 32'd1 : 32'd2);
        chk(((mon_r.id == 0) ? m0_rdata : m1_rdata) === mon_r.data, "rdata",
            32'((mon_r.id == 0) ? m0_rdata : m1_rdata), 32'(mon_r.data));
      end
    end else begin
      while (rdq.size() > 0 && rdq[0].due <= cyc) begin
        mon_r = rdq.pop_front();
        checks++;
        errors++;
        $display("FAIL missing_rvalid @cyc %0d: got none expected id %0d due %0d", cyc, mon_r.id, mon_r.due);
      end
    end
  end

  initial begin
    int  base;
    bit  found;
    m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;

    // Both requesters held through reset, then 16 cycles of contention (fills all addresses).
    for (int i = 0; i < 8; i++) begin
      issue(0, 1'b1, i,     DW'(16'h1000 + i));
      issue(1, 1'b1, 8 + i, DW'(16'h2000 + i));
    end
    repeat (3) step(1'b0);
    base = nsteps;
    repeat (16) step(1'b1);
    sync();
    for (int i = 0; i < 16; i++)
      chk(dlog[base+i] == (i / 4) % 2, "burst_pattern", dlog[base+i], (i / 4) % 2);

    // Write then read back on m0.
    issue(0, 1'b1, 3, 16'hA5A5);
    issue(0, 1'b0, 3, '0);
    repeat (RD_LAT + 3) step(1'b1);

    // m1 alone is never cut off; m0 joining is served within MAX_BURST cycles.
    for (int i = 0; i < 14; i++) issue(1, 1'b0, int'($urandom_range(15)), '0);
    base = nsteps;
    repeat (10) step(1'b1);
    sync();
    for (int i = 0; i < 10; i++) chk(dlog[base+i] == 1, "m1_solo", dlog[base+i], 1);
    issue(0, 1'b0, 5, '0);
    base = nsteps;
    repeat (MAX_BURST) step(1'b1);
    sync();
    found = 1'b0;
    for (int i = 0; i < MAX_BURST; i++) if (dlog[base+i] == 0) found = 1'b1;
    chk(found, "m0_join_wait", 32'(found), 32'd1);
    repeat (8) step(1'b1);

    // Alternating back-to-back reads at address 0 and the top address.
    issue(0, 1'b1, 0, 16'h0001);
    issue(1, 1'b1, 15, 16'hFFFF);
    repeat (3) step(1'b1);
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) issue(0, 1'b0, 0, '0);
      else            issue(1, 1'b0, 15, '0);
      step(1'b1);
    end
    repeat (RD_LAT + 2) step(1'b1);

    // Reset while a read is in flight: it must never return; grants resume afterwards.
    issue(0, 1'b0, 3, '0);
    step(1'b1);
    step(1'b0);
    step(1'b0);
    issue(0, 1'b1, 7, 16'h7777);
    issue(0, 1'b0, 3, '0);
    issue(1, 1'b0, 7, '0);
    repeat (RD_LAT + 6) step(1'b1);

    // Randomised traffic with idle gaps.
    prob = 60;
    for (int i = 0; i < 150; i++) begin
      issue(0, 1'($urandom_range(1)), int'($urandom_range(15)), DW'($urandom));
      issue(1, 1'($urandom_range(1)), int'($urandom_range(15)), DW'($urandom));
    end
    for (int n = 0; n < 1000 && (q0.size() > 0 || q1.size() > 0); n++) step(1'b1);
    chk(q0.size() + q1.size() == 0, "random_drain", q0.size() + q1.size(), 0);
    repeat (RD_LAT + 3) step(1'b1);
    sync();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
